rotary_encoder_ctrl: RTL

- Controller that sits behind the three debounce instances on the encoder A, B and push-switch pins.
- Decodes the debounced A/B quadrature into detent steps and maintains a bounded position register.
- Classifies the debounced switch into short and long press events.
- Output feeds the application logic (LED/UI) on the Tang Nano 9K; clk is the 27 MHz board clock.

---
 rtl/rotary_pkg.sv | 12 +
 rtl/rotary_encoder_ctrl_quad.sv | 47 ++++
 rtl/rotary_encoder_ctrl.sv | 93 +++++++++
 3 files changed

// File: rtl/rotary_pkg.sv
// rotary_pkg: button state encoding and quadrature transition lookup for the encoder controller.
package rotary_pkg;
  typedef enum logic [1:0] {IDLE, PRESSED, LONG} btn_state_e;
  typedef enum logic [1:0] {DIR_NONE, DIR_FWD, DIR_REV, DIR_ERR} quad_dir_e;
  // Indexed by {prev_ab, ab}; forward is 00 -> 01 -> 11 -> 10 -> 00
  localparam quad_dir_e QUAD_LUT [16] = '{
    DIR_NONE, DIR_FWD,  DIR_REV,  DIR_ERR,
    DIR_REV,  DIR_NONE, DIR_ERR,  DIR_FWD,
    DIR_FWD,  DIR_ERR,  DIR_NONE, DIR_REV,
    DIR_ERR,  DIR_REV,  DIR_FWD,  DIR_NONE
  };
endpackage

// File: rtl/rotary_encoder_ctrl_quad.sv
// quad_decoder: turns debounced A/B levels into detent step pulses and illegal-transition pulses.
module quad_decoder
  import rotary_pkg::*;
#(
  parameter int EDGES_PER_DETENT = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic enc_a,
  input  logic enc_b,
  output logic cw_evt,
  output logic ccw_evt,
  output logic step_cw,
  output logic step_ccw,
  output logic quad_err
);
  localparam logic signed [3:0] EPD = 4'(EDGES_PER_DETENT);
  logic [1:0] ab, prev_ab;
  logic first;
  logic signed [3:0] sub, sub_inc;
  quad_dir_e dir;
  assign ab = {enc_a, enc_b};
  // cw_evt/ccw_evt are the unregistered detent events so the position can move on the same edge
  always_comb begin
    dir = first ? DIR_NONE : QUAD_LUT[{prev_ab, ab}];
    sub_inc = sub + (dir == DIR_FWD ? 4'sd1 : dir == DIR_REV ? -4'sd1 : 4'sd0);
    cw_evt = sub_inc == EPD;
    ccw_evt = sub_inc == -EPD;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_ab <= 2'b00;
      first <= 1'b1;
      sub <= '0;
      step_cw <= 1'b0;
      step_ccw <= 1'b0;
      quad_err <= 1'b0;
    end else begin
      prev_ab <= ab;
      first <= 1'b0;
      sub <= (cw_evt || ccw_evt) ? 4'sd0 : sub_inc;
      step_cw <= cw_evt;
      step_ccw <= ccw_evt;
      quad_err <= dir == DIR_ERR;
    end
  end
endmodule

// File: rtl/rotary_encoder_ctrl.sv
// rotary_encoder_ctrl: bounded encoder position plus short/long press classification.
module rotary_encoder_ctrl
  import rotary_pkg::*;
#(
  parameter int POS_WIDTH = 8,
  parameter int POS_MIN = 0,
  parameter int POS_MAX = 255,
  parameter int POS_INIT = 0,
  parameter int WRAP = 0,
  parameter int EDGES_PER_DETENT = 4,
  parameter int LONG_CYCLES = 13500000
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 enc_a,
  input  logic                 enc_b,
  input  logic                 btn_rise,
  input  logic                 btn_fall,
  input  logic                 pos_load,
  input  logic [POS_WIDTH-1:0] pos_load_val,
  output logic [POS_WIDTH-1:0] pos,
  output logic                 step_cw,
  output logic                 step_ccw,
  output logic                 quad_err,
  output logic                 short_press,
  output logic                 long_press,
  output logic                 btn_held
);
  localparam int CW = $clog2(LONG_CYCLES + 1);
  localparam logic [POS_WIDTH-1:0] PMIN = POS_WIDTH'(POS_MIN);
  localparam logic [POS_WIDTH-1:0] PMAX = POS_WIDTH'(POS_MAX);
  localparam logic [POS_WIDTH-1:0] PINIT = POS_WIDTH'(POS_INIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(LONG_CYCLES - 1);
  logic cw_evt, ccw_evt;
  logic [POS_WIDTH-1:0] pos_nxt, load_c;
  btn_state_e state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic rise, fall, at_last, short_nxt, long_nxt, held_nxt;
  quad_decoder #(.EDGES_PER_DETENT(EDGES_PER_DETENT)) u_quad (
    .clk(clk),
    .rstn(rstn),
    .enc_a(enc_a),
    .enc_b(enc_b),
    .cw_evt(cw_evt),
    .ccw_evt(ccw_evt),
    .step_cw(step_cw),
    .step_ccw(step_ccw),
    .quad_err(quad_err)
  );
  // Limit checks happen before the +/-1 so the register never overflows
  always_comb begin
    load_c = pos_load_val <= PMIN ? PMIN : pos_load_val >= PMAX ? PMAX : pos_load_val;
    pos_nxt = pos_load ? load_c
            : cw_evt ? (pos == PMAX ? (WRAP != 0 ? PMIN : PMAX) : pos + 1'b1)
            : ccw_evt ? (pos == PMIN ? (WRAP != 0 ? PMAX : PMIN) : pos - 1'b1)
            : pos;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pos <= PINIT;
    else pos <= pos_nxt;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt <= '0;
      short_press <= 1'b0;
      long_press <= 1'b0;
      btn_held <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      short_press <= short_nxt;
      long_press <= long_nxt;
      btn_held <= held_nxt;
    end
  end
  // Coincident rise and fall cancel each other
  always_comb begin
    rise = btn_rise & ~btn_fall;
    fall = btn_fall & ~btn_rise;
    at_last = cnt == CNT_LAST;
    state_nxt = state == IDLE ? (rise ? PRESSED : IDLE)
              : state == PRESSED ? (fall ? IDLE : at_last ? LONG : PRESSED)
              : state == LONG ? (fall ? IDLE : LONG)
              : IDLE;
    cnt_nxt = state == IDLE ? '0 : (state == PRESSED && !at_last) ? cnt + 1'b1 : cnt;
  end
  always_comb begin
    short_nxt = state == PRESSED && fall && !at_last;
    long_nxt = state == PRESSED && at_last;
    held_nxt = state_nxt != IDLE;
  end
endmodule
